sysid_checker: RTL
==================

Name: sysid_checker

Overview:
- Avalon-MM master-side sequencer for the 1-bit-address, 32-bit system-ID slave.
- On request, reads word 0 (system ID) and then word 1 (build timestamp), using the waitrequest handshake.
- Compares both words against build-time expected values and retries on mismatch or timeout.
- Reports a sticky pass/fail status to the host-side control logic. This gates Ethernet datapath bring-up until the loaded image is confirmed.

Parameters:
- EXPECTED_ID, 1368189285: expected 32-bit word at address 0.
- EXPECTED_TS, 1327357851: expected 32-bit word at address 1.
- TIMEOUT_CYCLES, 255: maximum cycles a read may be held off by waitrequest. Range 1..65535.
- MAX_RETRIES, 3: additional full ID+TS sequences attempted after a failure. Range 0..15.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a check when idle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when a check sequence ends.
- pass  out  1  sticky; 1 = last check matched both words.
- timeout_err  out  1  sticky; 1 = last check ended on a timeout.
- id_value  out  32  last word captured from address 0.
- ts_value  out  32  last word captured from address 1.
- retry_count  out  4  retries consumed by the last check.
- avm_address  out  1  slave address: 0 = ID, 1 = timestamp.
- avm_read  out  1  read strobe.
- avm_readdata  in  32  slave read data.
- avm_waitrequest  in  1  slave stall.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - all outputs 0;
  - id_value and ts_value 0;
  - state IDLE;
  - retry and timeout counters 0.
- States: IDLE, RD_ID, RD_TS, CHECK, RETRY, FINISH.
- IDLE:
  - avm_read=0, busy=0.
  - start=1 clears pass, timeout_err and retry_count, then goes to RD_ID.
  - start is ignored in every other state.
- RD_ID:
  - avm_read=1, avm_address=0.
  - A transfer completes in the cycle where avm_read=1 and avm_waitrequest=0. That cycle captures avm_readdata into id_value (zero-latency slave), clears the timeout counter and goes to RD_TS.
- RD_TS:
  - Same as RD_ID, with avm_address=1, capture into ts_value, then go to CHECK.
- Control signals and avm_address are registered.
  - avm_read deasserts in the cycle after completion, or is held high across the RD_ID→RD_TS transition with the address changing.
  - avm_address must be stable whenever avm_read=1 and avm_waitrequest=1.
- Timeout:
  - In RD_ID or RD_TS, the timeout counter increments each cycle that avm_waitrequest=1.
  - When it reaches TIMEOUT_CYCLES: drop avm_read, set timeout_err, go to RETRY.
  - The counter width covers TIMEOUT_CYCLES.
- CHECK (one cycle):
  - Match (id_value==EXPECTED_ID and ts_value==EXPECTED_TS): set pass=1, clear timeout_err, go to FINISH.
  - Otherwise go to RETRY.
- RETRY:
  - If retry_count < MAX_RETRIES: increment retry_count, clear timeout_err, go to RD_ID.
  - Otherwise: pass=0, go to FINISH, with timeout_err retaining the last cause.
- FINISH: done=1 for exactly one cycle, busy=0 from the next cycle, return to IDLE.
- Latency with no stalls and a match:
  - start at cycle N, avm_read first high at N+1;
  - ID captured at N+1, TS captured at N+2;
  - CHECK at N+3, done at N+4.
- MAX_RETRIES=0: a single attempt only.
- retry_count saturates at MAX_RETRIES.
- Reset asserted mid-read: avm_read drops in the next cycle, all state returns to reset values, and no done pulse is generated.
- start coincident with reset: reset wins.
- pass, timeout_err, id_value and ts_value hold their values until the next accepted start.

Optional Feature:
- Macro: SYSID_CHECKER_AUTOSTART_EN.
- Defined: the first cycle after reset deasserts behaves as an internal start pulse, so one check runs automatically after every reset. External start behaves as normal afterwards.
- Undefined: no check runs until an external start pulse arrives.

Test Plan:
- Slave returns 1368189285/1327357851 with no waitrequest; start pulse → done 4 cycles later, pass=1, retry_count=0, timeout_err=0.
- Waitrequest held 10 cycles on address 0 → avm_address stable at 0 throughout; id_value captured on the release cycle; pass=1.
- Timestamp returns 0 on every read, MAX_RETRIES=3 → 4 full sequences (8 reads); done; pass=0; retry_count=3; timeout_err=0.
- Waitrequest stuck at 1, TIMEOUT_CYCLES=8, MAX_RETRIES=1 → two timeouts of 8 stall cycles each, then done with pass=0 and timeout_err=1.
- Reset pulsed while in RD_TS under a stall → next cycle avm_read=0, busy=0, all outputs 0, no done; a subsequent start completes normally.
- Autostart build: release reset with a matching slave → done and pass=1 with no external start; start pulses during busy are ignored.

Source files
------------

// File: rtl/sysid_checker.sv
// sysid_checker: reads the system ID (word 0) and build timestamp (word 1) over Avalon-MM,
// checks both against build-time constants and retries. Define SYSID_CHECKER_AUTOSTART_EN to auto-check after reset.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd1368189285,
    parameter logic [31:0] EXPECTED_TS    = 32'd1327357851,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  retry_count,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);
    localparam int unsigned     TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        RD_TS  = 3'd2,
        CHECK  = 3'd3,
        RETRY  = 3'd4,
        FINISH = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [3:0]      retry_d;
    logic            pass_d, toerr_d;
    logic [31:0]     id_d, ts_d;
    logic            busy_d, done_d, read_d, addr_d;
    logic            start_go;

`ifdef SYSID_CHECKER_AUTOSTART_EN
    // High for exactly the first cycle after reset is released
    logic auto_q;
    always_ff @(posedge clk) begin
        auto_q <= reset;
    end
    assign start_go = start | auto_q;
`else
    assign start_go = start;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        retry_d  = retry_count;
        pass_d   = pass;
        toerr_d  = timeout_err;
        id_d     = id_value;
        ts_d     = ts_value;

        case (state_q)
            IDLE: begin
                if (start_go) begin
                    pass_d   = 1'b0;
                    toerr_d  = 1'b0;
                    retry_d  = 4'd0;
                    to_cnt_d = '0;
                    state_d  = RD_ID;
                end
            end
            RD_ID, RD_TS: begin
                if (avm_read && !avm_waitrequest) begin
                    to_cnt_d = '0;
                    if (state_q == RD_ID) begin
                        id_d    = avm_readdata;
                        state_d = RD_TS;
                    end else begin
                        ts_d    = avm_readdata;
                        state_d = CHECK;
                    end
                end else if (avm_waitrequest) begin
                    if (to_cnt_q == TO_LAST) begin
                        to_cnt_d = '0;
                        toerr_d  = 1'b1;
                        state_d  = RETRY;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end
            CHECK: begin
                if (id_value == EXPECTED_ID && ts_value == EXPECTED_TS) begin
                    pass_d  = 1'b1;
                    toerr_d = 1'b0;
                    state_d = FINISH;
                end else begin
                    state_d = RETRY;
                end
            end
            RETRY: begin
                if (retry_count < RETRY_MAX) begin
                    retry_d = retry_count + 4'd1;
                    toerr_d = 1'b0;
                    state_d = RD_ID;
                end else begin
                    pass_d  = 1'b0;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bus and status strobes are registered copies of the next state
        read_d = (state_d == RD_ID) || (state_d == RD_TS);
        addr_d = (state_d == RD_TS);
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            to_cnt_q    <= '0;
            retry_count <= 4'd0;
            pass        <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            retry_count <= retry_d;
            pass        <= pass_d;
            timeout_err <= toerr_d;
            id_value    <= id_d;
            ts_value    <= ts_d;
            busy        <= busy_d;
            done        <= done_d;
            avm_read    <= read_d;
            avm_address <= addr_d;
        end
    end

endmodule
